// File: rtl/monolith_bars_seq.sv
// Monolith-31 Bars layer sequencer: time-multiplexes Bars lanes over the leading state elements.
// Optional MONOLITH_BARS_PIPE_EN registers lane outputs before write-back and adds a DRAIN state.
module monolith_bars_seq #(
    parameter int NUM_ELEMS      = 16,
    parameter int NUM_BARS       = 8,
    parameter int BARS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_ELEMS*31-1:0] in_state,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_ELEMS*31-1:0] out_state,
    output logic                    busy
);

    localparam int              IW    = $clog2(NUM_BARS) + 1;
    localparam int              SW    = NUM_ELEMS * 31;
    localparam logic [IW-1:0]   STEP  = IW'(BARS_PER_CYCLE);
    localparam logic [IW-1:0]   LAST  = IW'(NUM_BARS - BARS_PER_CYCLE);
    localparam logic [IW-1:0]   NBARS = IW'(NUM_BARS);

    if (BARS_PER_CYCLE < 1 || NUM_BARS < 1 || NUM_BARS > NUM_ELEMS) begin : g_bad_range
        $error("monolith_bars_seq: illegal NUM_BARS/NUM_ELEMS/BARS_PER_CYCLE combination");
    end else if ((NUM_BARS % BARS_PER_CYCLE) != 0) begin : g_bad_div
        $error("monolith_bars_seq: BARS_PER_CYCLE must divide NUM_BARS");
    end

    function automatic logic [7:0] sbox8(input logic [7:0] x);
        logic [7:0] nx;
        logic [7:0] t;
        nx = ~x;
        t  = x ^ ({nx[6:0], nx[7]} & {x[5:0], x[7:6]} & {x[4:0], x[7:5]});
        return {t[6:0], t[7]};
    endfunction

    function automatic logic [6:0] sbox7(input logic [6:0] x);
        logic [6:0] nx;
        logic [6:0] t;
        nx = ~x;
        t  = x ^ ({nx[5:0], nx[6]} & {x[4:0], x[6:5]});
        return {t[5:0], t[6]};
    endfunction

    // Chunks are processed independently and re-concatenated; no field reduction is applied.
    function automatic logic [30:0] barsElem(input logic [30:0] x);
        return {sbox7(x[30:24]), sbox8(x[23:16]), sbox8(x[15:8]), sbox8(x[7:0])};
    endfunction

`ifdef MONOLITH_BARS_PIPE_EN
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
`endif

    fsm_t            fsmQ;
    logic [SW-1:0]   stateQ;
    logic [SW-1:0]   stateD;
    logic [IW-1:0]   idxQ;
    logic [IW-1:0]   rdIdx;
    logic            inReadyQ;
    logic            outValidQ;
    logic            busyQ;
    logic [30:0]     laneD [BARS_PER_CYCLE];
`ifdef MONOLITH_BARS_PIPE_EN
    logic [30:0]     laneQ [BARS_PER_CYCLE];
`endif

    always_comb begin
        rdIdx  = (idxQ < NBARS) ? idxQ : '0;
        stateD = stateQ;
        for (int l = 0; l < BARS_PER_CYCLE; l++) begin
            laneD[l] = barsElem(stateQ[31*(int'(rdIdx)+l) +: 31]);
        end
`ifdef MONOLITH_BARS_PIPE_EN
        // Registered lanes hold the previous group, so write-back trails the read index by one group.
        if (idxQ >= STEP) begin
            for (int l = 0; l < BARS_PER_CYCLE; l++) begin
                stateD[31*(int'(idxQ - STEP)+l) +: 31] = laneQ[l];
            end
        end
`else
        for (int l = 0; l < BARS_PER_CYCLE; l++) begin
            stateD[31*(int'(rdIdx)+l) +: 31] = laneD[l];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsmQ      <= IDLE;
            stateQ    <= '0;
            idxQ      <= '0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
`ifdef MONOLITH_BARS_PIPE_EN
            for (int l = 0; l < BARS_PER_CYCLE; l++) begin
                laneQ[l] <= '0;
            end
`endif
        end else begin
            case (fsmQ)
                IDLE: begin
                    inReadyQ <= 1'b1;
                    if (in_valid && inReadyQ) begin
                        stateQ   <= in_state;
                        idxQ     <= '0;
                        fsmQ     <= RUN;
                        inReadyQ <= 1'b0;
                        busyQ    <= 1'b1;
                    end
                end
                RUN: begin
                    stateQ <= stateD;
                    idxQ   <= idxQ + STEP;
`ifdef MONOLITH_BARS_PIPE_EN
                    laneQ  <= laneD;
                    if (idxQ == LAST) begin
                        fsmQ <= DRAIN;
                    end
                end
                DRAIN: begin
                    stateQ    <= stateD;
                    fsmQ      <= DONE;
                    outValidQ <= 1'b1;
                end
`else
                    if (idxQ == LAST) begin
                        fsmQ      <= DONE;
                        outValidQ <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        fsmQ      <= IDLE;
                        outValidQ <= 1'b0;
                        busyQ     <= 1'b0;
                        inReadyQ  <= 1'b1;
                    end
                end
                default: fsmQ <= IDLE;
            endcase
        end
    end

    // Masking with rst keeps in_ready low for the whole reset cycle yet high right after it.
    assign in_ready  = inReadyQ & ~rst;
    assign out_valid = outValidQ;
    assign out_state = stateQ;
    assign busy      = busyQ;

endmodule

// File: tb/tb_monolith_bars_seq.sv
// Self-checking bench for monolith_bars_seq: directed steps with a scoreboard of expected states.
module tb_monolith_bars_seq;

   localparam int NE = 16;
   localparam int NB = 8;
   localparam int SW = NE * 31;
`ifdef MONOLITH_BARS_PIPE_EN
   localparam int PIPE_EXTRA = 1;
`else
   localparam int PIPE_EXTRA = 0;
`endif

   typedef logic [SW-1:0] vec_t;

   logic clk;
   logic rst;
   logic inValid;
   logic inValidW;
   logic outReady;
   vec_t inState;

   logic inReady, outValid, busy;
   vec_t outState;
   logic inReady4, outValid4, busy4;
   vec_t outState4;
   logic inReady8, outValid8, busy8;
   vec_t outState8;

   int checks = 0;
   int failures = 0;
   vec_t expQ[$];

   monolith_bars_seq #(.NUM_ELEMS(NE), .NUM_BARS(NB), .BARS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_state(inState),
      .out_valid(outValid), .out_ready(outReady), .out_state(outState), .busy(busy)
   );

   monolith_bars_seq #(.NUM_ELEMS(NE), .NUM_BARS(NB), .BARS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(inValidW), .in_ready(inReady4), .in_state(inState),
      .out_valid(outValid4), .out_ready(outReady), .out_state(outState4), .busy(busy4)
   );

   monolith_bars_seq #(.NUM_ELEMS(NE), .NUM_BARS(NB), .BARS_PER_CYCLE(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(inValidW), .in_ready(inReady8), .in_state(inState),
      .out_valid(outValid8), .out_ready(outReady), .out_state(outState8), .busy(busy8)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Last-resort guard so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference rotation written bit by bit so it does not share structure with the RTL.
   function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[(i + k) % 8] = v[i];
      return r;
   endfunction

   function automatic logic [6:0] rotl7(input logic [6:0] v, input int k);
      logic [6:0] r;
      for (int i = 0; i < 7; i++) r[(i + k) % 7] = v[i];
      return r;
   endfunction

   function automatic logic [7:0] sb8Ref(input logic [7:0] x);
      return rotl8(x ^ (rotl8(~x, 1) & rotl8(x, 2) & rotl8(x, 3)), 1);
   endfunction

   function automatic logic [6:0] sb7Ref(input logic [6:0] x);
      return rotl7(x ^ (rotl7(~x, 1) & rotl7(x, 2)), 1);
   endfunction

   function automatic logic [30:0] elemRef(input logic [30:0] x);
      logic [30:0] y;
      y[7:0]   = sb8Ref(x[7:0]);
      y[15:8]  = sb8Ref(x[15:8]);
      y[23:16] = sb8Ref(x[23:16]);
      y[30:24] = sb7Ref(x[30:24]);
      return y;
   endfunction

   function automatic vec_t stateRef(input vec_t s);
      vec_t r;
      r = s;
      for (int i = 0; i < NB; i++) r[31*i +: 31] = elemRef(s[31*i +: 31]);
      return r;
   endfunction

   function automatic logic [30:0] elemOf(input vec_t s, input int i);
      return s[31*i +: 31];
   endfunction

   function automatic vec_t randState();
      vec_t s;
      for (int i = 0; i < NE; i++) s[31*i +: 31] = 31'($urandom);
      return s;
   endfunction

   // Every comparison in the bench goes through this single assertion point.
   task automatic checkOutput(input string tag, input vec_t obs, input vec_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one state on the BARS_PER_CYCLE=1 instance and record its expected result.
   task automatic applyStimulus(input vec_t s);
      int guard;
      guard = 0;
      inState = s;
      inValid = 1'b1;
      while (!inReady && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("accept_ready", vec_t'(inReady), vec_t'(1));
      @(posedge clk); #1;
      inValid = 1'b0;
      expQ.push_back(stateRef(s));
   endtask

   // Called one step after the accept edge; lat counts edges up to the one that samples out_valid high.
   task automatic waitOutput(output int lat, output bit readySeen);
      lat = 1;
      readySeen = 1'b0;
      while (!outValid && lat < 40) begin
         readySeen |= inReady;
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("out_valid_seen", vec_t'(outValid), vec_t'(1));
   endtask

   task automatic checkScoreboard(input string tag);
      vec_t exp;
      checkOutput({tag, "_sb_size"}, vec_t'(expQ.size()), vec_t'(1));
      if (expQ.size() != 0) begin
         exp = expQ.pop_front();
         checkOutput(tag, outState, exp);
      end
   endtask

   initial begin
      int lat;
      bit readySeen;
      bit unstable;
      bit validSeen;
      vec_t s;
      vec_t held;
      vec_t exp;
      vec_t st1, st4, st8;
      int lat1, lat4, lat8;

      rst = 1'b1;
      inValid = 1'b0;
      inValidW = 1'b0;
      outReady = 1'b0;
      inState = '0;

      $display("[TB] reset");
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", vec_t'(inReady), vec_t'(0));
      checkOutput("rst_out_valid", vec_t'(outValid), vec_t'(0));
      checkOutput("rst_busy", vec_t'(busy), vec_t'(0));
      checkOutput("rst_state", outState, '0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", vec_t'(inReady), vec_t'(1));

      $display("[TB] all-zero state");
      outReady = 1'b1;
      applyStimulus('0);
      checkOutput("zero_busy", vec_t'(busy), vec_t'(1));
      waitOutput(lat, readySeen);
      checkOutput("zero_latency", vec_t'(lat), vec_t'(9 + PIPE_EXTRA));
      checkOutput("zero_in_ready_low", vec_t'(readySeen), vec_t'(0));
      checkOutput("zero_const", outState, '0);
      checkScoreboard("zero_state");
      @(posedge clk); #1;
      checkOutput("zero_after_valid", vec_t'(outValid), vec_t'(0));
      checkOutput("zero_after_ready", vec_t'(inReady), vec_t'(1));

      $display("[TB] uniform 0x01060606");
      for (int i = 0; i < NE; i++) s[31*i +: 31] = 31'h01060606;
      applyStimulus(s);
      waitOutput(lat, readySeen);
      checkOutput("uni_e0", vec_t'(elemOf(outState, 0)), vec_t'(31'h0A2C2C2C));
      checkOutput("uni_e7", vec_t'(elemOf(outState, 7)), vec_t'(31'h0A2C2C2C));
      checkOutput("uni_e8", vec_t'(elemOf(outState, 8)), vec_t'(31'h01060606));
      checkOutput("uni_e15", vec_t'(elemOf(outState, 15)), vec_t'(31'h01060606));
      checkScoreboard("uni_state");
      @(posedge clk); #1;

      $display("[TB] interleaved 0x7FFFFFFF / 0x00000001");
      for (int i = 0; i < NE; i++) s[31*i +: 31] = (i % 2 == 0) ? 31'h7FFFFFFF : 31'h00000001;
      applyStimulus(s);
      waitOutput(lat, readySeen);
      checkOutput("ilv_e0", vec_t'(elemOf(outState, 0)), vec_t'(31'h7FFFFFFF));
      checkOutput("ilv_e1", vec_t'(elemOf(outState, 1)), vec_t'(31'h00000002));
      checkOutput("ilv_e9", vec_t'(elemOf(outState, 9)), vec_t'(31'h00000001));
      checkScoreboard("ilv_state");
      @(posedge clk); #1;

      $display("[TB] backpressure in DONE");
      outReady = 1'b0;
      applyStimulus(randState());
      waitOutput(lat, readySeen);
      held = outState;
      unstable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (!outValid || outState !== held || inReady) unstable = 1'b1;
         @(posedge clk); #1;
      end
      checkOutput("hold_stable", vec_t'(unstable), vec_t'(0));
      checkOutput("hold_valid", vec_t'(outValid), vec_t'(1));
      checkOutput("hold_ready_before", vec_t'(inReady), vec_t'(0));
      checkScoreboard("hold_state");
      outReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("hold_ready_after", vec_t'(inReady), vec_t'(1));
      checkOutput("hold_valid_after", vec_t'(outValid), vec_t'(0));

      $display("[TB] reset during RUN");
      applyStimulus(randState());
      void'(expQ.pop_back());
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_valid", vec_t'(outValid), vec_t'(0));
      checkOutput("abort_busy", vec_t'(busy), vec_t'(0));
      rst = 1'b0;
      #1;
      checkOutput("abort_ready", vec_t'(inReady), vec_t'(1));
      validSeen = 1'b0;
      repeat (12) begin
         validSeen |= outValid;
         @(posedge clk); #1;
      end
      checkOutput("abort_no_output", vec_t'(validSeen), vec_t'(0));
      applyStimulus(randState());
      waitOutput(lat, readySeen);
      checkOutput("abort_new_latency", vec_t'(lat), vec_t'(9 + PIPE_EXTRA));
      checkScoreboard("abort_new_state");
      @(posedge clk); #1;

      $display("[TB] lane-count comparison");
      s = randState();
      exp = stateRef(s);
      inState = s;
      inValid = 1'b1;
      inValidW = 1'b1;
      checkOutput("wide_ready4", vec_t'(inReady4), vec_t'(1));
      @(posedge clk); #1;
      inValid = 1'b0;
      inValidW = 1'b0;
      expQ.push_back(exp);
      lat1 = 0; lat4 = 0; lat8 = 0;
      st1 = '0; st4 = '0; st8 = '0;
      for (int c = 1; c <= 30; c++) begin
         if (outValid && lat1 == 0) begin lat1 = c; st1 = outState; end
         if (outValid4 && lat4 == 0) begin lat4 = c; st4 = outState4; end
         if (outValid8 && lat8 == 0) begin lat8 = c; st8 = outState8; end
         if (lat1 != 0 && lat4 != 0 && lat8 != 0) break;
         @(posedge clk); #1;
      end
      checkOutput("wide_lat1", vec_t'(lat1), vec_t'(9 + PIPE_EXTRA));
      checkOutput("wide_lat4", vec_t'(lat4), vec_t'(3 + PIPE_EXTRA));
      checkOutput("wide_lat8", vec_t'(lat8), vec_t'(2 + PIPE_EXTRA));
      checkOutput("wide_state1", st1, expQ.pop_front());
      checkOutput("wide_state4", st4, exp);
      checkOutput("wide_state8", st8, exp);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("final_idle1", vec_t'(busy), vec_t'(0));
      checkOutput("final_idle4", vec_t'(busy4), vec_t'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
